// File: rtl/mss_ccc_sup_pkg.sv
// ---------------------------------------------------------------------------
// mss_ccc_sup_pkg
// Shared definitions for the MSS CCC lock supervisor:
//   - sup_state_e : supervisor FSM state encoding (also exported on STATE)
//   - LOSS_CNT_W  : width of the saturating loss-of-lock counter
//   - clog2       : ceiling log2 used to size the internal counters
// ---------------------------------------------------------------------------
package mss_ccc_sup_pkg;

    localparam int LOSS_CNT_W = 8;

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        RELEASE   = 3'd1,
        RUN       = 3'd2,
        FAULT     = 3'd3
    } sup_state_e;

    // Smallest r with 2**r >= value; clog2(1) is 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mss_ccc_lock_filter.sv
// ---------------------------------------------------------------------------
// mss_ccc_lock_filter
// One lock channel: a 2-FF synchroniser for the asynchronous PLL lock,
// followed by a saturating debounce counter. The registered status rises
// once the synchronised lock has been high (and the channel enabled) for
// STABLE_CYCLES consecutive cycles. It drops one cycle after the
// synchronised lock goes low, with no filtering on the falling side.
//
// Ports:
//   clk_i     supervisor clock
//   reset_i   synchronous active-high reset
//   lock_i    asynchronous PLL lock input
//   enable_i  channel enable; when low the counter is held at zero
//   status_o  debounced lock status (registered)
// ---------------------------------------------------------------------------
module mss_ccc_lock_filter
    import mss_ccc_sup_pkg::*;
#(
    parameter int STABLE_CYCLES = 1024
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic lock_i,
    input  logic enable_i,
    output logic status_o
);

    localparam int CNT_W = clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             status_q;
    logic             status_d;

    // The status is computed from the next count so that it rises exactly
    // STABLE_CYCLES cycles after the synchronised lock first reads high,
    // and falls on the very next edge once the counter is cleared.
    always_comb begin
        cnt_d = '0;
        if (sync2_q && enable_i) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        end
        status_d = (cnt_d == CNT_MAX);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            cnt_q    <= '0;
            status_q <= 1'b0;
        end else begin
            sync1_q  <= lock_i;
            sync2_q  <= sync1_q;
            cnt_q    <= cnt_d;
            status_q <= status_d;
        end
    end

    assign status_o = status_q;

endmodule

// File: rtl/mss_ccc_lock_supervisor.sv
// ---------------------------------------------------------------------------
// mss_ccc_lock_supervisor
// Watches N_CH PLL lock inputs, releases the per-domain resets one slot at a
// time (GAP_CYCLES apart, ascending index) once every enabled channel has a
// stable lock, and drops back to full reset on any loss of lock while
// releasing or running. Lost channels are latched in LOST_LOCK and every
// fault entry bumps a saturating LOSS_COUNT.
//
// Ports:
//   CLK          supervisor clock
//   RESET        synchronous active-high reset
//   LOCK_IN      asynchronous PLL lock inputs, one per channel
//   CH_ENABLE    channels taking part in the sequence
//   CLR_FAULT    single-cycle pulse: clears LOST_LOCK, leaves FAULT when
//                AUTO_RESTART is 0
//   RST_OUT      per-domain reset, active-high
//   ALL_LOCKED   high only while in RUN
//   LOCK_STATUS  debounced lock per channel
//   LOST_LOCK    sticky loss-of-lock flags
//   LOSS_COUNT   saturating count of fault entries
//   STATE        FSM state for debug
// ---------------------------------------------------------------------------
module mss_ccc_lock_supervisor
    import mss_ccc_sup_pkg::*;
#(
    parameter int N_CH          = 3,
    parameter int STABLE_CYCLES = 1024,
    parameter int GAP_CYCLES    = 16,
    parameter bit AUTO_RESTART  = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [N_CH-1:0]       LOCK_IN,
    input  logic [N_CH-1:0]       CH_ENABLE,
    input  logic                  CLR_FAULT,
    output logic [N_CH-1:0]       RST_OUT,
    output logic                  ALL_LOCKED,
    output logic [N_CH-1:0]       LOCK_STATUS,
    output logic [N_CH-1:0]       LOST_LOCK,
    output logic [LOSS_CNT_W-1:0] LOSS_COUNT,
    output logic [2:0]            STATE
);

    // A one-cycle gap still needs a one-bit counter that simply stays at 0.
    localparam int GAP_W  = (clog2(GAP_CYCLES) < 1) ? 1 : clog2(GAP_CYCLES);
    localparam int SLOT_W = clog2(N_CH + 1);
    localparam logic [GAP_W-1:0]  LAST_GAP  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(N_CH);

    sup_state_e            state_q;
    sup_state_e            state_d;
    logic [GAP_W-1:0]      gap_q;
    logic [GAP_W-1:0]      gap_d;
    logic [SLOT_W-1:0]     slot_q;
    logic [SLOT_W-1:0]     slot_d;
    logic [N_CH-1:0]       rel_q;
    logic [N_CH-1:0]       rel_d;
    logic [N_CH-1:0]       rst_q;
    logic [N_CH-1:0]       lost_q;
    logic [N_CH-1:0]       lost_d;
    logic [LOSS_CNT_W-1:0] loss_q;
    logic [LOSS_CNT_W-1:0] loss_d;
    logic [N_CH-1:0]       status_prev_q;
    logic [N_CH-1:0]       lock_status;
    logic [N_CH-1:0]       drop;
    logic                  fault_hit;
    logic                  all_ready;

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_filter
        mss_ccc_lock_filter #(
            .STABLE_CYCLES(STABLE_CYCLES)
        ) u_filter (
            .clk_i   (CLK),
            .reset_i (RESET),
            .lock_i  (LOCK_IN[ch]),
            .enable_i(CH_ENABLE[ch]),
            .status_o(lock_status[ch])
        );
    end

    // A fault is a falling edge of the debounced status on a channel that is
    // still enabled. A channel that is disabled loses its status too, but its
    // enable is already low on that cycle, so it never counts as a loss.
    assign drop      = status_prev_q & ~lock_status & CH_ENABLE;
    assign fault_hit = ((state_q == RELEASE) || (state_q == RUN)) && (|drop);
    assign all_ready = (|CH_ENABLE) && ((lock_status & CH_ENABLE) == CH_ENABLE);

    // Next-state logic. rel_d is the set of domains currently let out of
    // reset; masking it with CH_ENABLE every cycle means a disabled domain
    // goes back into reset and stays there until the next release pass.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        slot_d  = slot_q;
        rel_d   = rel_q & CH_ENABLE;
        lost_d  = CLR_FAULT ? '0 : lost_q;
        loss_d  = loss_q;

        case (state_q)
            WAIT_LOCK: begin
                rel_d  = '0;
                gap_d  = '0;
                slot_d = '0;
                if (all_ready) begin
                    state_d  = RELEASE;
                    rel_d[0] = CH_ENABLE[0];
                end
            end
            RELEASE: begin
                if (gap_q == LAST_GAP) begin
                    gap_d  = '0;
                    slot_d = slot_q + SLOT_W'(1);
                    if (slot_d == LAST_SLOT) begin
                        state_d = RUN;
                    end else begin
                        for (int k = 0; k < N_CH; k++) begin
                            if (slot_d == SLOT_W'(k)) begin
                                rel_d[k] = CH_ENABLE[k];
                            end
                        end
                    end
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            RUN: begin
                state_d = RUN;
            end
            FAULT: begin
                rel_d = '0;
                if (AUTO_RESTART || CLR_FAULT) begin
                    state_d = WAIT_LOCK;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                rel_d   = '0;
            end
        endcase

        // A loss overrides everything: full reset, and the set of a lost
        // bit wins over a CLR_FAULT arriving on the same cycle.
        if (fault_hit) begin
            state_d = FAULT;
            rel_d   = '0;
            lost_d  = lost_d | drop;
            if (loss_q != '1) begin
                loss_d = loss_q + LOSS_CNT_W'(1);
            end
        end
    end

    // All supervisor state, including the registered reset outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q       <= WAIT_LOCK;
            gap_q         <= '0;
            slot_q        <= '0;
            rel_q         <= '0;
            rst_q         <= '1;
            lost_q        <= '0;
            loss_q        <= '0;
            status_prev_q <= '0;
        end else begin
            state_q       <= state_d;
            gap_q         <= gap_d;
            slot_q        <= slot_d;
            rel_q         <= rel_d;
            rst_q         <= ~rel_d;
            lost_q        <= lost_d;
            loss_q        <= loss_d;
            status_prev_q <= lock_status;
        end
    end

    assign RST_OUT     = rst_q;
    assign ALL_LOCKED  = (state_q == RUN);
    assign LOCK_STATUS = lock_status;
    assign LOST_LOCK   = lost_q;
    assign LOSS_COUNT  = loss_q;
    assign STATE       = state_q;

endmodule

// File: tb/tb_mss_ccc_lock_supervisor.sv
// ---------------------------------------------------------------------------
// tb_mss_ccc_lock_supervisor
// Two supervisors (N_CH=3, STABLE_CYCLES=8, GAP_CYCLES=4): dutA restarts
// automatically after a fault, dutM waits for CLR_FAULT. Each has its own
// inputs and is driven by its own sequence. Expected outputs are queued with
// the cycle they must appear on and compared on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_mss_ccc_lock_supervisor;

    localparam int N = 3;
    localparam int S = 8;
    localparam int G = 4;

    localparam int F_RST   = 0;
    localparam int F_ALL   = 1;
    localparam int F_STAT  = 2;
    localparam int F_LOST  = 3;
    localparam int F_CNT   = 4;
    localparam int F_STATE = 5;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic         resetA = 1'b1, clrA = 1'b0;
    logic [N-1:0] lockA = '0, enA = '1;
    logic [N-1:0] rstA, statA, lostA;
    logic         allA;
    logic [7:0]   cntA;
    logic [2:0]   stateA;

    logic         resetM = 1'b1, clrM = 1'b0;
    logic [N-1:0] lockM = '0, enM = '1;
    logic [N-1:0] rstM, statM, lostM;
    logic         allM;
    logic [7:0]   cntM;
    logic [2:0]   stateM;

    mss_ccc_lock_supervisor #(
        .N_CH(N), .STABLE_CYCLES(S), .GAP_CYCLES(G), .AUTO_RESTART(1'b1)
    ) dutA (
        .CLK(clock), .RESET(resetA), .LOCK_IN(lockA), .CH_ENABLE(enA),
        .CLR_FAULT(clrA), .RST_OUT(rstA), .ALL_LOCKED(allA),
        .LOCK_STATUS(statA), .LOST_LOCK(lostA), .LOSS_COUNT(cntA),
        .STATE(stateA)
    );

    mss_ccc_lock_supervisor #(
        .N_CH(N), .STABLE_CYCLES(S), .GAP_CYCLES(G), .AUTO_RESTART(1'b0)
    ) dutM (
        .CLK(clock), .RESET(resetM), .LOCK_IN(lockM), .CH_ENABLE(enM),
        .CLR_FAULT(clrM), .RST_OUT(rstM), .ALL_LOCKED(allM),
        .LOCK_STATUS(statM), .LOST_LOCK(lostM), .LOSS_COUNT(cntM),
        .STATE(stateM)
    );

    typedef struct {
        int         cyc;
        int         dut;
        int         fld;
        logic [7:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic expectAt(input int c, input int d, input int f, input logic [7:0] v);
        exp_t e;
        e.cyc = c;
        e.dut = d;
        e.fld = f;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic expectSeq(input int c, input int d, input logic [7:0] rst,
                             input logic [7:0] all, input logic [7:0] st);
        expectAt(c, d, F_RST, rst);
        expectAt(c, d, F_ALL, all);
        expectAt(c, d, F_STATE, st);
    endtask

    task automatic expectReset(input int c, input int d);
        expectSeq(c, d, 8'd7, 8'd0, 8'd0);
        expectAt(c, d, F_STAT, 8'd0);
        expectAt(c, d, F_LOST, 8'd0);
        expectAt(c, d, F_CNT, 8'd0);
    endtask

    task automatic waitCycle(input int c);
        while (cyc < c) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic applyStimulus(input int d, input int c, input logic [N-1:0] lock,
                                 input logic [N-1:0] en, input logic clr, input logic rst);
        waitCycle(c);
        if (d == 0) begin
            lockA = lock; enA = en; clrA = clr; resetA = rst;
        end else begin
            lockM = lock; enM = en; clrM = clr; resetM = rst;
        end
    endtask

    function automatic logic [7:0] getField(input int d, input int f);
        logic [7:0] r;
        r = 8'hEE;
        case (f)
            F_RST:   r = (d == 0) ? {5'd0, rstA}   : {5'd0, rstM};
            F_ALL:   r = (d == 0) ? {7'd0, allA}   : {7'd0, allM};
            F_STAT:  r = (d == 0) ? {5'd0, statA}  : {5'd0, statM};
            F_LOST:  r = (d == 0) ? {5'd0, lostA}  : {5'd0, lostM};
            F_CNT:   r = (d == 0) ? cntA           : cntM;
            F_STATE: r = (d == 0) ? {5'd0, stateA} : {5'd0, stateM};
            default: r = 8'hEE;
        endcase
        return r;
    endfunction

    function automatic string fieldName(input int f);
        case (f)
            F_RST:   return "RST_OUT";
            F_ALL:   return "ALL_LOCKED";
            F_STAT:  return "LOCK_STATUS";
            F_LOST:  return "LOST_LOCK";
            F_CNT:   return "LOSS_COUNT";
            default: return "STATE";
        endcase
    endfunction

    // Pop every expectation due this cycle and compare it against the DUT.
    always @(negedge clock) begin : monitor
        int i;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].cyc == cyc) begin
                checkOutput($sformatf("%s_%s@%0d", (sb[i].dut == 0) ? "A" : "M",
                                      fieldName(sb[i].fld), cyc),
                            {24'd0, getField(sb[i].dut, sb[i].fld)}, {24'd0, sb[i].val});
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic runA();
        int t;
        applyStimulus(0, 0, 3'b000, 3'b111, 1'b0, 1'b1);
        expectReset(3, 0);
        applyStimulus(0, 4, 3'b000, 3'b111, 1'b0, 1'b0);

        // Channel 1 only pulses for 5 cycles: never debounced, no release.
        applyStimulus(0, 6, 3'b111, 3'b111, 1'b0, 1'b0);
        applyStimulus(0, 11, 3'b101, 3'b111, 1'b0, 1'b0);
        expectAt(16, 0, F_STAT, 8'd5);
        expectSeq(16, 0, 8'd7, 8'd0, 8'd0);
        expectSeq(24, 0, 8'd7, 8'd0, 8'd0);
        expectAt(24, 0, F_STAT, 8'd5);

        // Channel 1 locks at 30 -> all stable at 40, spaced release.
        applyStimulus(0, 30, 3'b111, 3'b111, 1'b0, 1'b0);
        expectAt(40, 0, F_STAT, 8'd7);
        expectSeq(40, 0, 8'd7, 8'd0, 8'd0);
        expectSeq(41, 0, 8'd6, 8'd0, 8'd1);
        expectSeq(44, 0, 8'd6, 8'd0, 8'd1);
        expectSeq(45, 0, 8'd4, 8'd0, 8'd1);
        expectSeq(48, 0, 8'd4, 8'd0, 8'd1);
        expectSeq(49, 0, 8'd0, 8'd0, 8'd1);
        expectSeq(52, 0, 8'd0, 8'd0, 8'd1);
        expectSeq(53, 0, 8'd0, 8'd1, 8'd2);

        // Loss on channel 2 while running.
        applyStimulus(0, 60, 3'b011, 3'b111, 1'b0, 1'b0);
        expectAt(62, 0, F_STAT, 8'd7);
        expectAt(63, 0, F_STAT, 8'd3);
        expectSeq(63, 0, 8'd0, 8'd1, 8'd2);
        expectSeq(64, 0, 8'd7, 8'd0, 8'd3);
        expectAt(64, 0, F_LOST, 8'd4);
        expectAt(64, 0, F_CNT, 8'd1);
        expectSeq(65, 0, 8'd7, 8'd0, 8'd0);
        expectAt(65, 0, F_LOST, 8'd4);

        // Re-lock repeats the release sequence.
        applyStimulus(0, 70, 3'b111, 3'b111, 1'b0, 1'b0);
        expectSeq(80, 0, 8'd7, 8'd0, 8'd0);
        expectSeq(81, 0, 8'd6, 8'd0, 8'd1);
        expectSeq(85, 0, 8'd4, 8'd0, 8'd1);
        expectSeq(89, 0, 8'd0, 8'd0, 8'd1);
        expectSeq(93, 0, 8'd0, 8'd1, 8'd2);
        expectAt(93, 0, F_CNT, 8'd1);
        expectAt(93, 0, F_LOST, 8'd4);

        // Reset from RUN, then sequence with channel 1 disabled.
        applyStimulus(0, 100, 3'b111, 3'b101, 1'b0, 1'b1);
        expectReset(101, 0);
        applyStimulus(0, 102, 3'b111, 3'b101, 1'b0, 1'b0);
        expectAt(112, 0, F_STAT, 8'd5);
        expectSeq(112, 0, 8'd7, 8'd0, 8'd0);
        expectSeq(113, 0, 8'd6, 8'd0, 8'd1);
        expectSeq(117, 0, 8'd6, 8'd0, 8'd1);
        expectSeq(121, 0, 8'd2, 8'd0, 8'd1);
        expectSeq(125, 0, 8'd2, 8'd1, 8'd2);

        // Losing lock on the disabled channel is ignored.
        applyStimulus(0, 130, 3'b101, 3'b101, 1'b0, 1'b0);
        expectSeq(140, 0, 8'd2, 8'd1, 8'd2);
        expectAt(140, 0, F_LOST, 8'd0);
        expectAt(140, 0, F_CNT, 8'd0);

        // Disable channel 0 in RUN: back into reset, no fault.
        applyStimulus(0, 145, 3'b101, 3'b100, 1'b0, 1'b0);
        expectSeq(146, 0, 8'd3, 8'd1, 8'd2);
        expectAt(146, 0, F_LOST, 8'd0);
        expectAt(150, 0, F_STAT, 8'd4);
        expectAt(150, 0, F_CNT, 8'd0);

        // Re-enabled channel 0 relocks but stays in reset.
        applyStimulus(0, 155, 3'b101, 3'b101, 1'b0, 1'b0);
        expectSeq(165, 0, 8'd3, 8'd1, 8'd2);
        expectAt(165, 0, F_STAT, 8'd5);
        expectAt(165, 0, F_LOST, 8'd0);

        // No channels enabled: never leaves WAIT_LOCK.
        applyStimulus(0, 170, 3'b111, 3'b000, 1'b0, 1'b1);
        applyStimulus(0, 172, 3'b111, 3'b000, 1'b0, 1'b0);
        expectSeq(200, 0, 8'd7, 8'd0, 8'd0);
        expectAt(200, 0, F_STAT, 8'd0);

        // Reset in the middle of RELEASE.
        applyStimulus(0, 205, 3'b111, 3'b111, 1'b0, 1'b1);
        applyStimulus(0, 207, 3'b111, 3'b111, 1'b0, 1'b0);
        expectSeq(218, 0, 8'd6, 8'd0, 8'd1);
        expectSeq(220, 0, 8'd6, 8'd0, 8'd1);
        applyStimulus(0, 220, 3'b111, 3'b111, 1'b0, 1'b1);
        expectReset(221, 0);
        applyStimulus(0, 222, 3'b111, 3'b111, 1'b0, 1'b0);
        expectSeq(233, 0, 8'd6, 8'd0, 8'd1);

        // 300 forced faults: one-cycle lock glitch on channel 0 each time
        // the FSM is back in RELEASE (every 12 cycles).
        for (int k = 0; k < 300; k++) begin
            t = 234 + 12 * k;
            if (k == 0 || k == 253 || k == 254 || k == 255 || k == 299) begin
                expectAt(t + 4, 0, F_CNT, (k + 1 > 255) ? 8'd255 : 8'(k + 1));
                expectSeq(t + 4, 0, 8'd7, 8'd0, 8'd3);
            end
            if (k == 299) begin
                expectAt(t + 4, 0, F_LOST, 8'd1);
                expectSeq(t + 5, 0, 8'd7, 8'd0, 8'd0);
            end
            applyStimulus(0, t, 3'b110, 3'b111, 1'b0, 1'b0);
            applyStimulus(0, t + 1, 3'b111, 3'b111, 1'b0, 1'b0);
        end
        waitCycle(234 + 12 * 300 + 2);
    endtask

    task automatic runM();
        applyStimulus(1, 0, 3'b000, 3'b111, 1'b0, 1'b1);
        expectReset(3, 1);
        applyStimulus(1, 4, 3'b000, 3'b111, 1'b0, 1'b0);

        applyStimulus(1, 6, 3'b111, 3'b111, 1'b0, 1'b0);
        expectSeq(17, 1, 8'd6, 8'd0, 8'd1);
        expectSeq(29, 1, 8'd0, 8'd1, 8'd2);

        // Fault holds until CLR_FAULT.
        applyStimulus(1, 40, 3'b011, 3'b111, 1'b0, 1'b0);
        expectAt(43, 1, F_STAT, 8'd3);
        expectSeq(44, 1, 8'd7, 8'd0, 8'd3);
        expectAt(44, 1, F_LOST, 8'd4);
        expectAt(44, 1, F_CNT, 8'd1);
        applyStimulus(1, 45, 3'b111, 3'b111, 1'b0, 1'b0);
        expectSeq(60, 1, 8'd7, 8'd0, 8'd3);
        expectAt(60, 1, F_LOST, 8'd4);
        expectAt(60, 1, F_STAT, 8'd7);

        applyStimulus(1, 62, 3'b111, 3'b111, 1'b1, 1'b0);
        applyStimulus(1, 63, 3'b111, 3'b111, 1'b0, 1'b0);
        expectSeq(63, 1, 8'd7, 8'd0, 8'd0);
        expectAt(63, 1, F_LOST, 8'd0);
        expectAt(63, 1, F_CNT, 8'd1);
        expectSeq(64, 1, 8'd6, 8'd0, 8'd1);
        expectSeq(76, 1, 8'd0, 8'd1, 8'd2);

        // CLR_FAULT on the same cycle as a new loss: the set wins.
        applyStimulus(1, 80, 3'b101, 3'b111, 1'b0, 1'b0);
        applyStimulus(1, 83, 3'b101, 3'b111, 1'b1, 1'b0);
        applyStimulus(1, 84, 3'b101, 3'b111, 1'b0, 1'b0);
        expectSeq(84, 1, 8'd7, 8'd0, 8'd3);
        expectAt(84, 1, F_LOST, 8'd2);
        expectAt(84, 1, F_CNT, 8'd2);
        expectSeq(90, 1, 8'd7, 8'd0, 8'd3);
        expectAt(90, 1, F_LOST, 8'd2);

        applyStimulus(1, 92, 3'b101, 3'b111, 1'b1, 1'b0);
        applyStimulus(1, 93, 3'b101, 3'b111, 1'b0, 1'b0);
        expectSeq(93, 1, 8'd7, 8'd0, 8'd0);
        expectAt(93, 1, F_LOST, 8'd0);
        expectAt(93, 1, F_CNT, 8'd2);
        expectSeq(95, 1, 8'd7, 8'd0, 8'd0);
        waitCycle(100);
    endtask

    initial begin
        fork
            runA();
            runM();
        join
        waitCycle(cyc + 3);
        checkOutput("scoreboard_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mss_ccc_lock_supervisor.md
Name: mss_ccc_lock_supervisor

Overview:
Parametrised lock supervisor and reset sequencer that sits downstream of the MSS CCC / fabric PLL wrappers. It synchronises and debounces N_CH asynchronous PLL lock inputs, then releases per-domain synchronous resets in a fixed, spaced order. It detects loss of lock, re-asserts all domain resets and records the fault. It generalises the single FAB_LOCK/MSS_LOCK pair to N channels, with stability filtering, sequencing and fault handling.

Parameters:
N_CH, 3, number of lock channels / reset domains (1..8)
STABLE_CYCLES, 1024, consecutive synchronised-high cycles before a lock is considered stable (>=2)
GAP_CYCLES, 16, cycles between successive domain reset releases (>=1)
AUTO_RESTART, 1, 1: FAULT returns to WAIT_LOCK automatically; 0: FAULT waits for CLR_FAULT

Ports:
CLK  in  1  supervisor clock (free-running, e.g. RCOSC/MAINXIN-derived)
RESET  in  1  synchronous, active-high reset
LOCK_IN  in  N_CH  asynchronous PLL lock inputs
CH_ENABLE  in  N_CH  channel participates in sequencing; static except in WAIT_LOCK
CLR_FAULT  in  1  single-cycle pulse; clears LOST_LOCK and exits FAULT when AUTO_RESTART=0
RST_OUT  out  N_CH  per-domain reset, active-high
ALL_LOCKED  out  1  high only in RUN
LOCK_STATUS  out  N_CH  debounced lock per channel
LOST_LOCK  out  N_CH  sticky loss-of-lock flags
LOSS_COUNT  out  8  saturating count of fault entries
STATE  out  3  FSM state encoding, for debug

Behaviour:
- Reset values: RST_OUT all 1; ALL_LOCKED 0; LOCK_STATUS 0; LOST_LOCK 0; LOSS_COUNT 0; STATE=WAIT_LOCK (0).
- Synchroniser: 2-FF per channel. LOCK_IN rising at cycle t gives sync high at t+2.
- Debounce counter per channel:
  - Counts while sync is high and CH_ENABLE is 1. Clears to 0 when sync is low or the channel is disabled.
  - LOCK_STATUS[i] goes to 1 at t+2+STABLE_CYCLES.
  - LOCK_STATUS[i] goes to 0 the cycle after sync goes low. There is no debounce on the falling edge.
- FSM states and transitions:
  - WAIT_LOCK (0): all RST_OUT=1. If at least one channel is enabled and every enabled channel has LOCK_STATUS=1 at cycle c, go to RELEASE. In RELEASE, RST_OUT[0] falls at c+1.
  - RELEASE (1):
    - RST_OUT[k] falls at c+1+k*GAP_CYCLES, ascending index.
    - A disabled channel still consumes its slot but stays at 1.
    - STATE=RUN and ALL_LOCKED=1 at c+1+N_CH*GAP_CYCLES.
  - RUN (2): resets held released. ALL_LOCKED=1.
  - FAULT (3): entered the cycle after any enabled channel's LOCK_STATUS falls while in RELEASE or RUN. On the same edge:
    - All RST_OUT go to 1 and ALL_LOCKED goes to 0.
    - LOST_LOCK[i] is set for each dropping channel.
    - LOSS_COUNT increments, saturating at 255.
  - FAULT exit: if AUTO_RESTART=1, go to WAIT_LOCK next cycle. Otherwise stay until CLR_FAULT, then go to WAIT_LOCK next cycle.
- Lock drop in WAIT_LOCK is not a fault. The FSM keeps waiting and the debounce counter restarts.
- No channels enabled: the FSM stays in WAIT_LOCK and ALL_LOCKED stays 0.
- CLR_FAULT clears all LOST_LOCK bits. If a new loss occurs in the same cycle, the set wins for that bit. LOSS_COUNT is cleared only by RESET.
- Channel disabled while in RELEASE/RUN: its RST_OUT goes to 1 next cycle and no fault is raised. A newly enabled channel stays in reset until the next WAIT_LOCK→RELEASE pass.
- RESET mid-sequence: returns to reset values on the next edge. Debounce counters and synchroniser flops are cleared.
- Debounce counter width is clog2(STABLE_CYCLES+1), saturating. Gap counter width is clog2(GAP_CYCLES). Slot index width is clog2(N_CH+1).

Decomposition:
- Package mss_ccc_sup_pkg: state enum (WAIT_LOCK=0, RELEASE=1, RUN=2, FAULT=3), clog2 helper, LOSS_COUNT width constant (8).
- Sub-module mss_ccc_lock_filter, one instance per channel. It contains the 2-FF synchroniser, the debounce counter and the LOCK_STATUS register, with an enable input.
- Top level holds the FSM, gap/slot counters, fault flags and counter.

Test Plan:
- N_CH=3, STABLE=8, GAP=4, all enabled, all LOCK_IN rise at cycle 10 -> LOCK_STATUS=111 at 20; RST_OUT[0] low at 21, [1] at 25, [2] at 29; ALL_LOCKED=1, STATE=2 at 33.
- Same setup, LOCK_IN[1] pulses high for 5 cycles only -> LOCK_STATUS[1] never rises; FSM stays in WAIT_LOCK; RST_OUT=111.
- In RUN, drop LOCK_IN[2] at cycle 50 -> LOCK_STATUS[2]=0 at 53; FAULT, RST_OUT=111, LOST_LOCK=100, LOSS_COUNT=1 at 54; WAIT_LOCK at 55. Re-lock repeats the release sequence.
- AUTO_RESTART=0, fault as above -> STATE stays 3. CLR_FAULT pulse -> LOST_LOCK=000 and WAIT_LOCK next cycle. CLR_FAULT coincident with a new loss -> bit stays set.
- CH_ENABLE=101 -> channel 1 stays in reset throughout; RST_OUT[2] still falls at c+9; dropping LOCK_IN[1] causes no fault. CH_ENABLE=000 -> ALL_LOCKED stays 0.
- 300 forced faults -> LOSS_COUNT saturates at 255. RESET asserted mid-RELEASE -> all outputs at reset values next cycle.
